sync_fifo_fwft: RTL

//   Single-clock parametrised FIFO with two read modes:
//   - standard: registered read data;
//   - first-word-fall-through (FWFT): the head word is visible without a read.

---
 rtl/sync_fifo_fwft_pkg.sv | 26 ++
 rtl/sync_fifo_fwft_ram.sv | 28 ++
 rtl/sync_fifo_fwft.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/sync_fifo_fwft_pkg.sv
// Shared constants and types for the single-clock FIFO family.
// Mode encodings select registered (standard) or fall-through read data.
package sync_fifo_fwft_pkg;

    localparam int FIFO_DEF_DATA_WIDTH = 8;
    localparam int FIFO_DEF_DEPTH      = 16;
    localparam bit FIFO_MODE_STD       = 1'b0;
    localparam bit FIFO_MODE_FWFT      = 1'b1;

    // Encoded as {rd_ok, wr_ok} so the accepted operation can drive a case directly.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_e;

    function automatic logic err_next(
        input logic i_err_now,
        input logic i_err_sticky,
        input logic i_clr
    );
        return i_err_now | (i_err_sticky & ~i_clr);
    endfunction

endpackage

// File: rtl/sync_fifo_fwft_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
// The read port is combinational so the top can use it for fall-through data.
module fifo_ram
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 16,
    localparam int ADDR_W     = $clog2(DEPTH)
)(
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_W-1:0]     i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_W-1:0]     i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Write port; contents are never cleared by reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with standard or first-word-fall-through read data,
// occupancy count, almost-full/empty flags and sticky overflow/underflow.
module sync_fifo_fwft
    import sync_fifo_fwft_pkg::*;
#(
    parameter  int DATA_WIDTH = FIFO_DEF_DATA_WIDTH,
    parameter  int DEPTH      = FIFO_DEF_DEPTH,
    parameter  bit FWFT       = FIFO_MODE_STD,
    parameter  int AF_LEVEL   = 12,
    parameter  int AE_LEVEL   = 4,
    localparam int ADDR_W     = $clog2(DEPTH)
)(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_din,
    input  logic                  i_rd_en,
    input  logic                  i_clr_err,
    output logic [DATA_WIDTH-1:0] o_dout,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_almost_full,
    output logic                  o_almost_empty,
    output logic [ADDR_W:0]       o_count,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    typedef logic [ADDR_W:0]   cnt_t;
    typedef logic [ADDR_W-1:0] ptr_t;

    localparam cnt_t CNT_ONE  = cnt_t'(1);
    localparam cnt_t CNT_ZERO = cnt_t'(0);
    localparam cnt_t CNT_FULL = cnt_t'(DEPTH);
    localparam cnt_t CNT_AF   = cnt_t'(AF_LEVEL);
    localparam cnt_t CNT_AE   = cnt_t'(AE_LEVEL);
    localparam ptr_t PTR_ONE  = ptr_t'(1);
    localparam ptr_t PTR_ZERO = ptr_t'(0);

    ptr_t                  r_wr_ptr;
    ptr_t                  r_rd_ptr;
    cnt_t                  r_count;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_almost_full;
    logic                  r_almost_empty;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_rd_ok;
    logic                  w_wr_ok;
    logic                  w_ram_we;
    fifo_op_e              w_op;
    cnt_t                  w_count_nxt;
    logic [DATA_WIDTH-1:0] w_ram_rdata;

    // Acceptance uses the registered flags, so a read on an empty FIFO is
    // rejected even when a write lands in the same cycle.
    assign w_rd_ok  = i_rd_en & ~r_empty;
    assign w_wr_ok  = i_wr_en & (~r_full | w_rd_ok);
    assign w_op     = fifo_op_e'({w_rd_ok, w_wr_ok});
    assign w_ram_we = w_wr_ok & ~i_rst;

    // Next occupancy from the accepted operation pair.
    always_comb begin
        w_count_nxt = r_count;
        case (w_op)
            OP_WRITE: w_count_nxt = r_count + CNT_ONE;
            OP_READ:  w_count_nxt = r_count - CNT_ONE;
            OP_BOTH:  w_count_nxt = r_count;
            OP_IDLE:  w_count_nxt = r_count;
            default:  w_count_nxt = r_count;
        endcase
    end

    // Pointers, count and flags; flags derive from the next count so they
    // move on the same edge as the count itself.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr       <= PTR_ZERO;
            r_rd_ptr       <= PTR_ZERO;
            r_count        <= CNT_ZERO;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_count        <= w_count_nxt;
            r_full         <= (w_count_nxt == CNT_FULL);
            r_empty        <= (w_count_nxt == CNT_ZERO);
            r_almost_full  <= (w_count_nxt >= CNT_AF);
            r_almost_empty <= (w_count_nxt <= CNT_AE);
            r_overflow     <= err_next(i_wr_en & ~w_wr_ok, r_overflow, i_clr_err);
            r_underflow    <= err_next(i_rd_en & ~w_rd_ok, r_underflow, i_clr_err);
        end
    end

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_ram_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (i_din),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_ram_rdata)
    );

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            // Head word is visible directly; meaningless while empty.
            assign o_dout = w_ram_rdata;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_dout;

            // Registered read data, held between accepted reads.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_dout <= {DATA_WIDTH{1'b0}};
                end else if (w_rd_ok) begin
                    r_dout <= w_ram_rdata;
                end
            end

            assign o_dout = r_dout;
        end
    endgenerate

    assign o_full         = r_full;
    assign o_empty        = r_empty;
    assign o_almost_full  = r_almost_full;
    assign o_almost_empty = r_almost_empty;
    assign o_count        = r_count;
    assign o_overflow     = r_overflow;
    assign o_underflow    = r_underflow;

endmodule
